// File: rtl/generic_rr_arbiter_if.sv
// Valid/ready bundle between NUMBER producers, the round-robin arbiter and one consumer.
// GENERIC_ARB_LOCK_EN adds the per-source end-of-packet marker in_last_i.
interface generic_rr_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int NUMBER = 4
);
    localparam int SelectW = (NUMBER > 1) ? $clog2(NUMBER) : 1;

    logic [NUMBER-1:0]  in_valid_i;
    logic [NUMBER-1:0]  in_ready_o;
    logic [WIDTH-1:0]   in_data_i [NUMBER];
`ifdef GENERIC_ARB_LOCK_EN
    logic [NUMBER-1:0]  in_last_i;
`endif
    logic               out_valid_o;
    logic               out_ready_i;
    logic [WIDTH-1:0]   out_data_o;
    logic [SelectW-1:0] out_sel_o;

    modport slave (
`ifdef GENERIC_ARB_LOCK_EN
        input  in_last_i,
`endif
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_sel_o
    );

    modport master (
`ifdef GENERIC_ARB_LOCK_EN
        output in_last_i,
`endif
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_sel_o
    );
endinterface

// File: rtl/generic_rr_arbiter.sv
// Registered round-robin N:1 stream arbiter: 1 cycle accept-to-output, full rate; a stalled output holds its word and drops all ready bits.
// GENERIC_ARB_LOCK_EN: once a multi-beat packet wins, the grant stays on that source until its last beat.
module generic_rr_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NUMBER = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    generic_rr_arbiter_if.slave   bus
);
    localparam int SelectW = (NUMBER > 1) ? $clog2(NUMBER) : 1;
    localparam logic [SelectW-1:0] LastIdx = SelectW'(NUMBER - 1);

    logic [SelectW-1:0] ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SelectW-1:0] out_sel_q, out_sel_d;

    logic [SelectW-1:0] scan_start;
    logic [SelectW-1:0] scan_grant;
    logic [SelectW-1:0] scan_cand;
    logic               scan_found;
    int                 scan_idx;
    logic [SelectW-1:0] grant;
    logic               grant_last;
    logic               slot_free;
    logic               accept;
    logic [NUMBER-1:0]  in_ready;

    // Search begins one past the last winner, wrapping for non-power-of-two NUMBER.
    assign scan_start = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;

    always_comb begin
        scan_grant = scan_start;
        scan_found = 1'b0;
        scan_idx   = 0;
        scan_cand  = '0;
        for (int k = 0; k < NUMBER; k++) begin
            scan_idx = int'(scan_start) + k;
            if (scan_idx >= NUMBER) begin
                scan_idx = scan_idx - NUMBER;
            end
            scan_cand = scan_idx[SelectW-1:0];
            if (!scan_found && bus.in_valid_i[scan_cand]) begin
                scan_grant = scan_cand;
                scan_found = 1'b1;
            end
        end
    end

`ifdef GENERIC_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e        state_q, state_d;
    logic [SelectW-1:0] lock_idx_q, lock_idx_d;

    assign grant      = (state_q == ST_LOCKED) ? lock_idx_q : scan_grant;
    assign grant_last = bus.in_last_i[grant];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!grant_last) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant;
                    end
                end
                ST_LOCKED: begin
                    if (grant_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
`else
    assign grant      = scan_grant;
    assign grant_last = 1'b1;
`endif

    assign slot_free = !out_valid_q || bus.out_ready_i;
    assign accept    = bus.in_valid_i[grant] && slot_free;

    // Ready follows the grant alone, never the other sources' valids.
    always_comb begin
        in_ready        = '0;
        in_ready[grant] = slot_free;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data_i[grant];
            out_sel_d   = grant;
            if (grant_last) begin
                ptr_d = grant;
            end
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= LastIdx;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_sel_o   = out_sel_q;

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(in_ready));

    a_stall_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_q && !bus.out_ready_i) |=> ($stable(out_data_q) && $stable(out_sel_q)));
`endif
endmodule

// File: tb/tb_generic_rr_arbiter.sv
// Bench for generic_rr_arbiter: 4-source and 3-source instances against a cycle model.
module tb_generic_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    generic_rr_arbiter_if #(.WIDTH(32), .NUMBER(4)) bus4 ();
    generic_rr_arbiter_if #(.WIDTH(32), .NUMBER(3)) bus3 ();

    generic_rr_arbiter #(.WIDTH(32), .NUMBER(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
    generic_rr_arbiter #(.WIDTH(32), .NUMBER(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester cyclically after ptr; with no requester the nominal grant is ptr+1.
    function automatic int scan(input int n, input int ptr, input logic [63:0] v);
        for (int k = 1; k <= n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return (ptr + 1) % n;
    endfunction

    // Model state: the word the output register must hold after the next edge.
    logic        m4_valid, m3_valid;
    logic [31:0] m4_data, m3_data;
    int          m4_sel, m3_sel, m4_ptr, m3_ptr;
    logic        m4_locked;
    int          m4_lock;

    always @(negedge clk) begin : cmp4
        int   g;
        logic sf;
        logic last;
        if (rst) begin
            check("rst_out_valid", bus4.out_valid_o, 0);
            check("rst_out_data", bus4.out_data_o, 0);
            check("rst_out_sel", bus4.out_sel_o, 0);
            m4_valid  = 1'b0;
            m4_data   = '0;
            m4_sel    = 0;
            m4_ptr    = 3;
            m4_locked = 1'b0;
            m4_lock   = 0;
        end else begin
            g  = m4_locked ? m4_lock : scan(4, m4_ptr, 64'(bus4.in_valid_i));
            sf = !m4_valid || bus4.out_ready_i;
            check("in_ready", bus4.in_ready_o, sf ? (64'd1 << g) : 64'd0);
            check("out_valid", bus4.out_valid_o, m4_valid);
            if (m4_valid) begin
                check("out_data", bus4.out_data_o, m4_data);
                check("out_sel", bus4.out_sel_o, m4_sel);
            end
            last = 1'b1;
`ifdef GENERIC_ARB_LOCK_EN
            last = bus4.in_last_i[g];
`endif
            if (sf && bus4.in_valid_i[g]) begin
                m4_valid = 1'b1;
                m4_data  = bus4.in_data_i[g];
                m4_sel   = g;
                if (last) begin
                    m4_ptr    = g;
                    m4_locked = 1'b0;
                end else begin
                    m4_locked = 1'b1;
                    m4_lock   = g;
                end
            end else if (bus4.out_ready_i) begin
                m4_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp3
        int   g;
        logic sf;
        if (rst) begin
            m3_valid = 1'b0;
            m3_data  = '0;
            m3_sel   = 0;
            m3_ptr   = 2;
        end else begin
            g  = scan(3, m3_ptr, 64'(bus3.in_valid_i));
            sf = !m3_valid || bus3.out_ready_i;
            check("n3_in_ready", bus3.in_ready_o, sf ? (64'd1 << g) : 64'd0);
            check("n3_out_valid", bus3.out_valid_o, m3_valid);
            if (m3_valid) begin
                check("n3_out_data", bus3.out_data_o, m3_data);
                check("n3_out_sel", bus3.out_sel_o, m3_sel);
            end
            if (sf && bus3.in_valid_i[g]) begin
                m3_valid = 1'b1;
                m3_data  = bus3.in_data_i[g];
                m3_sel   = g;
                m3_ptr   = g;
            end else if (bus3.out_ready_i) begin
                m3_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic all_valid4(input logic [31:0] base);
        bus4.in_valid_i = 4'b1111;
        for (int i = 0; i < 4; i++) bus4.in_data_i[i] = base + 32'(i);
    endtask

    initial begin
        rst = 1'b1;
        bus4.in_valid_i  = '0;
        bus4.out_ready_i = 1'b0;
        bus3.in_valid_i  = '0;
        bus3.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) bus4.in_data_i[i] = '0;
        for (int i = 0; i < 3; i++) bus3.in_data_i[i] = '0;
`ifdef GENERIC_ARB_LOCK_EN
        bus4.in_last_i = '1;
        bus3.in_last_i = '1;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request from source 2.
        do_reset();
        check("reset_valid", bus4.out_valid_o, 0);
        check("reset_sel", bus4.out_sel_o, 0);
        bus4.in_valid_i   = 4'b0100;
        bus4.in_data_i[2] = 32'hA5;
        bus4.out_ready_i  = 1'b1;
        #1 check("single_ready", bus4.in_ready_o, 4'b0100);
        cyc();
        check("single_valid", bus4.out_valid_o, 1);
        check("single_data", bus4.out_data_o, 32'hA5);
        check("single_sel", bus4.out_sel_o, 2);
        bus4.in_valid_i = '0;

        // Full-rate rotation, then idle cycles leave the pointer alone.
        do_reset();
        all_valid4(32'h0);
        bus4.out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("rot_valid", bus4.out_valid_o, 1);
            check("rot_sel", bus4.out_sel_o, k % 4);
        end
        bus4.in_valid_i = '0;
        cyc();
        cyc();
        check("idle_valid", bus4.out_valid_o, 0);
        bus4.in_valid_i = 4'b1111;
        cyc();
        check("idle_resume_sel", bus4.out_sel_o, 2);

        // Backpressure: one word captured, then a frozen output.
        do_reset();
        all_valid4(32'h100);
        bus4.out_ready_i = 1'b0;
        cyc();
        check("bp_first_sel", bus4.out_sel_o, 0);
        check("bp_first_data", bus4.out_data_o, 32'h100);
        repeat (4) begin
            cyc();
            check("bp_ready_low", bus4.in_ready_o, 0);
            check("bp_data_hold", bus4.out_data_o, 32'h100);
        end
        bus4.out_ready_i = 1'b1;
        #1 check("bp_release_ready", bus4.in_ready_o, 4'b0010);
        cyc();
        check("bp_release_sel", bus4.out_sel_o, 1);
        check("bp_release_data", bus4.out_data_o, 32'h101);

        // Three-source wrap with sparse requests.
        do_reset();
        bus4.in_valid_i  = '0;
        bus3.in_valid_i  = 3'b101;
        bus3.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) bus3.in_data_i[i] = 32'h30 + 32'(i);
        #1 check("n3_wrap_ready0", bus3.in_ready_o, 3'b001);
        cyc();
        check("n3_wrap_sel0", bus3.out_sel_o, 0);
        check("n3_wrap_ready2", bus3.in_ready_o, 3'b100);
        cyc();
        check("n3_wrap_sel2", bus3.out_sel_o, 2);
        check("n3_wrap_data2", bus3.out_data_o, 32'h32);
        bus3.in_valid_i = '0;

        // Asynchronous reset while a word is held.
        do_reset();
        all_valid4(32'h200);
        bus4.out_ready_i = 1'b0;
        cyc();
        check("ar_valid_before", bus4.out_valid_o, 1);
        #2 rst = 1'b1;
        #1 check("ar_valid_cleared", bus4.out_valid_o, 0);
        check("ar_data_cleared", bus4.out_data_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus4.out_ready_i = 1'b1;
        cyc();
        check("ar_first_sel", bus4.out_sel_o, 0);
        check("ar_first_data", bus4.out_data_o, 32'h200);

`ifdef GENERIC_ARB_LOCK_EN
        // Source 1 holds the grant for a 3-beat packet while source 0 waits.
        do_reset();
        all_valid4(32'h300);
        bus4.in_valid_i  = 4'b0001;
        bus4.in_last_i   = 4'b1111;
        bus4.out_ready_i = 1'b1;
        cyc();
        check("lock_pre_sel", bus4.out_sel_o, 0);
        bus4.in_valid_i = 4'b0011;
        bus4.in_last_i  = 4'b0001;
        cyc();
        check("lock_beat1", bus4.out_sel_o, 1);
        cyc();
        check("lock_beat2", bus4.out_sel_o, 1);
        bus4.in_last_i = 4'b0011;
        cyc();
        check("lock_beat3", bus4.out_sel_o, 1);
        cyc();
        check("lock_after", bus4.out_sel_o, 0);
        bus4.in_last_i = 4'b1111;
`endif

        // Random traffic on both instances, with one mid-run reset.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (c == 700) begin
                do_reset();
            end
            bus4.in_valid_i  = 4'($urandom);
            bus4.out_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) bus4.in_data_i[i] = $urandom;
            bus3.in_valid_i  = 3'($urandom);
            bus3.out_ready_i = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 3; i++) bus3.in_data_i[i] = $urandom;
`ifdef GENERIC_ARB_LOCK_EN
            bus4.in_last_i = 4'($urandom);
`endif
        end
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
